// File: rtl/sign_narrow.sv
// sign_narrow: packs a signed IN_W-bit datapath value into a signed OUT_W-bit
// immediate. The stage is a single registered slot with valid/ready handshakes
// on both sides. Values that do not fit are flagged, counted in a saturating
// counter and recorded in a sticky bit.
//
// Build option: SIGN_NARROW_SAT_EN
//   defined   - an overflowing value saturates to the most negative or most
//               positive OUT_W code
//   undefined - an overflowing value is truncated to its low OUT_W bits
//
// state | meaning
// ------+------------------------------------------
// EMPTY | output register holds nothing
// FULL  | output register holds one result (out_valid=1)

module sign_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                    accept;
    logic                    consume;
    logic [IN_W-OUT_W:0]     upper;
    logic                    fits;
    logic [OUT_W-1:0]        narrowed;

    // Upstream may push whenever the slot is free or is being drained this cycle.
    assign in_ready = !rst && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // A value fits when every bit from the sign bit down to the OUT_W sign
    // position is a copy of the same value.
    assign upper = in_data[IN_W-1:OUT_W-1];
    assign fits  = (&upper) || !(|upper);

    // Choose the narrowed code, substituting the clamp value on overflow when enabled.
    always_comb begin
        narrowed = in_data[OUT_W-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (!fits) begin
            if (in_data[IN_W-1]) begin
                narrowed = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                narrowed = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
`endif
    end

    // Next-state and valid decode for the single-entry output slot.
    always_comb begin
        state_nxt = state;
        out_valid = (state == FULL);
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (consume && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State register; reset discards any held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output data register loads on every accept and otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            out_data <= narrowed;
            out_ovf  <= !fits;
        end
    end

    // Overflow bookkeeping; clr takes priority over a same-cycle overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (accept && !fits) begin
            ovf_sticky <= 1'b1;
            if (!(&ovf_count)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: directed-vector bench for sign_narrow (default parameters).
// Expected data values follow the SIGN_NARROW_SAT_EN build selection.

module tb_sign_narrow;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_data;
    logic        out_ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        clr;

    int checks;
    int failures;

`ifdef SIGN_NARROW_SAT_EN
    localparam logic [5:0] EXP_0020 = 6'h1F;
    localparam logic [5:0] EXP_8000 = 6'h20;
    localparam logic [5:0] EXP_FFDF = 6'h20;
    localparam logic [5:0] EXP_7FFF = 6'h1F;
`else
    localparam logic [5:0] EXP_0020 = 6'h20;
    localparam logic [5:0] EXP_8000 = 6'h00;
    localparam logic [5:0] EXP_FFDF = 6'h1F;
    localparam logic [5:0] EXP_7FFF = 6'h3F;
`endif

    sign_narrow dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr        (clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        clr       = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 6'h00);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_sticky", ovf_sticky, 1'b0);
        check("rst_count", ovf_count, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Fitting values, 1-cycle latency
        in_valid = 1'b1;
        in_data  = 16'h0005;
        tick();
        check("fit05_valid", out_valid, 1'b1);
        check("fit05_data", out_data, 6'h05);
        check("fit05_ovf", out_ovf, 1'b0);
        in_data = 16'hFFE0;
        tick();
        check("fitm32_data", out_data, 6'h20);
        check("fitm32_ovf", out_ovf, 1'b0);
        in_data = 16'h001F;
        tick();
        check("fit31_data", out_data, 6'h1F);
        check("fit31_ovf", out_ovf, 1'b0);
        check("fit_count", ovf_count, 8'd0);
        check("fit_sticky", ovf_sticky, 1'b0);

        // Positive and negative overflow
        in_data = 16'h0020;
        tick();
        check("pos_ovf", out_ovf, 1'b1);
        check("pos_data", out_data, EXP_0020);
        check("pos_count", ovf_count, 8'd1);
        check("pos_sticky", ovf_sticky, 1'b1);
        in_data = 16'h8000;
        tick();
        check("neg_ovf", out_ovf, 1'b1);
        check("neg_data", out_data, EXP_8000);
        check("neg_count", ovf_count, 8'd2);
        in_data = 16'hFFDF;
        tick();
        check("m33_ovf", out_ovf, 1'b1);
        check("m33_data", out_data, EXP_FFDF);
        check("m33_count", ovf_count, 8'd3);

        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0003;
        tick();
        check("bp_load_valid", out_valid, 1'b1);
        check("bp_load_data", out_data, 6'h03);
        in_data = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 1'b0);
            tick();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data", out_data, 6'h03);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        for (int i = 4; i < 8; i++) begin
            in_data = 16'(i);
            tick();
            check("stream_valid", out_valid, 1'b1);
            check("stream_data", out_data, 6'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", out_valid, 1'b0);

        // Counter clear, saturation, clr priority
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count", ovf_count, 8'd0);
        check("clr_sticky", ovf_sticky, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        for (int i = 0; i < 255; i++) tick();
        check("cnt_255", ovf_count, 8'd255);
        for (int i = 0; i < 5; i++) tick();
        check("cnt_sat", ovf_count, 8'd255);
        check("cnt_sticky", ovf_sticky, 1'b1);
        in_data = 16'h7FFF;
        clr     = 1'b1;
        tick();
        clr = 1'b0;
        check("clrwin_count", ovf_count, 8'd0);
        check("clrwin_sticky", ovf_sticky, 1'b0);
        check("clrwin_ovf", out_ovf, 1'b1);
        check("clrwin_data", out_data, EXP_7FFF);
        in_valid = 1'b0;
        tick();

        // Reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0040;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_sticky", ovf_sticky, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 6'h00);
        check("mid_rst_ovf", out_ovf, 1'b0);
        check("mid_rst_sticky", ovf_sticky, 1'b0);
        check("mid_rst_count", ovf_count, 8'd0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0002;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        tick();
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_data", out_data, 6'h02);
        check("post_rst_ovf", out_ovf, 1'b0);
        in_valid = 1'b0;
        tick();
        check("post_rst_drain", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
Name: sign_narrow

Overview:
- Inverse of the immediate sign-extension path: converts a 16-bit signed datapath value into a 6-bit signed immediate field.
- Used by the instruction-encode/writeback path whenever a computed offset must be packed back into a 6-bit immediate.
- Single-stage registered pipeline with valid/ready handshakes on both sides.
- Detects values that do not fit in 6 bits, flags them, and counts them.

Parameters:
- IN_W, 16, input width in bits.
- OUT_W, 6, output width in bits; must be in the range 2 to IN_W-1.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  IN_W  signed value to narrow.
- out_valid  output  1  out_data and out_ovf are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  OUT_W  narrowed signed value.
- out_ovf  output  1  the value held in out_data did not fit in OUT_W bits.
- ovf_sticky  output  1  set by any accepted overflow; cleared only by clr or rst.
- ovf_count  output  CNT_W  number of accepted overflows, saturating.
- clr  input  1  synchronous clear of ovf_count and ovf_sticky.

Behaviour:
- Reset, asynchronous, while rst=1:
  - out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
  - FSM goes to EMPTY.
  - in_ready=0 while rst is asserted.
- FSM states:
  - EMPTY: output register holds nothing.
  - FULL: output register holds one result.
  - out_valid=1 exactly in FULL.
- Handshake:
  - in_ready = !rst && (state==EMPTY || out_ready). This is combinational from out_ready and gives full throughput.
  - An input is accepted when in_valid && in_ready.
  - The output is consumed when out_valid && out_ready.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + consume + no accept -> EMPTY.
  - FULL + consume + accept -> FULL, with the new result loaded.
  - FULL + no consume -> FULL; out_data and out_ovf are held stable.
- Latency: 1 cycle from accept to out_valid.
- Fit rule: in_data fits iff bits [IN_W-1:OUT_W-1] are all equal.
  - Fits: out_data = in_data[OUT_W-1:0], out_ovf=0.
  - Does not fit: out_ovf=1, and out_data is chosen as described under Optional Feature.
- Counter:
  - On each accepted overflow, ovf_count increments by 1 and ovf_sticky is set to 1.
  - ovf_count saturates at 2^CNT_W-1; it never wraps.
- clr:
  - Clears ovf_count and ovf_sticky on the next edge.
  - If clr and an overflow accept occur in the same cycle, clr wins: the result is count=0 and sticky=0.
  - The overflowing result itself still reaches out_data/out_ovf normally.
- clr does not affect the data path or the FSM.
- Reset mid-transfer: a held FULL result is discarded; no partial output is produced.

Optional Feature:
- Macro: SIGN_NARROW_SAT_EN.
- Defined: on overflow, out_data saturates.
  - Negative input -> most negative code (OUT_W=6: 6'h20, i.e. -32).
  - Positive input -> most positive code (6'h1F, i.e. 31).
- Undefined: on overflow, out_data = in_data[OUT_W-1:0] (wrap/truncate).
- out_ovf, ovf_sticky and ovf_count behave identically in both builds.

Test Plan:
- Fitting values: in_data 16'h0005 -> out_data 6'h05, ovf 0. in_data 16'hFFE0 (-32) -> out_data 6'h20, ovf 0. Both with 1-cycle latency and out_ready=1.
- Positive overflow: in_data 16'h0020 (32) -> ovf 1, ovf_count 1, ovf_sticky 1. out_data 6'h1F with SAT_EN, 6'h20 without.
- Negative overflow: in_data 16'h8000 -> ovf 1. out_data 6'h20 with SAT_EN, 6'h00 without.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_data stays stable. Then raise out_ready for a back-to-back stream of 4 values -> one result per cycle, in order, none lost or duplicated.
- Counter: 260 consecutive overflowing inputs -> ovf_count ends at 255. clr asserted in the same cycle as an overflow accept -> count 0, sticky 0.
- Reset mid-operation: assert rst while FULL with out_ready=0 -> out_valid drops immediately and all outputs are 0. After release, the first accepted input behaves normally.
